// File: rtl/gb_dma_pkg.sv
// gb_dma_pkg: definitions shared by the OAM DMA controller and the mmu.
//   dma_state_t  : DMA sequencer states
//   DMA_REG_ADDR : the FF46 DMA trigger/readback register address
//   HRAM_LO/HI   : the HRAM window that stays reachable while DMA runs
//   ECHO_BASE    : source pages at or above this value alias C000-DFFF
//   echo_map()   : translates a source page to the page actually read
package gb_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2,
    LAST  = 2'd3
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] HRAM_LO      = 16'hFF80;
  localparam logic [15:0] HRAM_HI      = 16'hFFFE;
  localparam logic [7:0]  ECHO_BASE    = 8'hE0;

  // Pages E0-FF are the echo of work RAM, so they are read from C0-DF.
  function automatic logic [7:0] echo_map(input logic [7:0] src);
    return (src >= ECHO_BASE) ? (src - 8'h20) : src;
  endfunction

endpackage

// File: rtl/oam_dma_controller.sv
// oam_dma_controller: sequences the OAM DMA transfer started by a CPU write
// to FF46. Copies LENGTH bytes from {src,8'h00} into OAM, one byte every
// CYCLES_PER_BYTE clocks, after STARTUP_DELAY idle clocks.
// Ports:
//   iClock, iReset     : clock, asynchronous active-low reset
//   iCpuAddr/We/Data   : CPU bus, watched for the FF46 trigger
//   oDmaReg            : FF46 readback (last value written)
//   oDmaActive         : transfer in progress
//   oCpuBlocked        : CPU bus blocked (all but HRAM and FF46)
//   oDmaReadAddr       : source address into the mmu read mux
//   iDmaReadData       : source byte returned by the mmu
//   oOamWe/Addr/Data   : OAM write port
module oam_dma_controller
  import gb_dma_pkg::*;
#(
  parameter int LENGTH          = 160,
  parameter int CYCLES_PER_BYTE = 4,
  parameter int STARTUP_DELAY   = 4
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iCpuAddr,
  input  logic        iCpuWe,
  input  logic [7:0]  iCpuData,
  output logic [7:0]  oDmaReg,
  output logic        oDmaActive,
  output logic        oCpuBlocked,
  output logic [15:0] oDmaReadAddr,
  input  logic [7:0]  iDmaReadData,
  output logic        oOamWe,
  output logic [7:0]  oOamAddr,
  output logic [7:0]  oOamData
);

  localparam int SW = $clog2(CYCLES_PER_BYTE);
  localparam int DW = (STARTUP_DELAY > 1) ? $clog2(STARTUP_DELAY) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(CYCLES_PER_BYTE - 1);
  localparam logic [DW-1:0] DELAY_LAST = DW'(STARTUP_DELAY - 1);
  localparam logic [7:0]    IDX_LAST   = 8'(LENGTH - 1);

  dma_state_t    state_reg, state_next;
  logic [7:0]    dma_reg_reg;   // FF46 value; doubles as the source page
  logic [7:0]    idx_reg;
  logic [SW-1:0] slot_reg;
  logic [DW-1:0] delay_reg;
  logic          oam_we_reg;
  logic [7:0]    oam_addr_reg;
  logic [7:0]    oam_data_reg;

  logic trigger;
  logic slot_end;
  logic in_hram;

  assign trigger  = iCpuWe && (iCpuAddr == DMA_REG_ADDR);
  assign slot_end = (slot_reg == SLOT_LAST);

  // State register
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic; a trigger restarts from any state
  always_comb begin
    state_next = state_reg;
    if (trigger) begin
      state_next = START;
    end else begin
      case (state_reg)
        IDLE:    state_next = IDLE;
        START:   if (delay_reg == DELAY_LAST) state_next = XFER;
        XFER:    if (slot_end && idx_reg == IDX_LAST) state_next = LAST;
        LAST:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Counters and the registered OAM write port
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      dma_reg_reg  <= 8'h00;
      idx_reg      <= 8'h00;
      slot_reg     <= '0;
      delay_reg    <= '0;
      oam_we_reg   <= 1'b0;
      oam_addr_reg <= 8'h00;
      oam_data_reg <= 8'h00;
    end else if (trigger) begin
      // Restart also cancels a write that would have issued next clock
      dma_reg_reg <= iCpuData;
      idx_reg     <= 8'h00;
      slot_reg    <= '0;
      delay_reg   <= '0;
      oam_we_reg  <= 1'b0;
    end else begin
      oam_we_reg <= 1'b0;
      case (state_reg)
        START: delay_reg <= delay_reg + 1'b1;
        XFER: begin
          if (slot_end) begin
            oam_data_reg <= iDmaReadData;
            oam_addr_reg <= idx_reg;
            oam_we_reg   <= 1'b1;
            slot_reg     <= '0;
            // idx stops at the final byte, so it never wraps
            if (idx_reg != IDX_LAST) idx_reg <= idx_reg + 8'd1;
          end else begin
            slot_reg <= slot_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    oDmaActive   = (state_reg != IDLE);
    oDmaReadAddr = 16'h0000;
    if (oDmaActive) oDmaReadAddr = {echo_map(dma_reg_reg), idx_reg};
    in_hram      = (iCpuAddr >= HRAM_LO) && (iCpuAddr <= HRAM_HI);
    oCpuBlocked  = oDmaActive && !in_hram && (iCpuAddr != DMA_REG_ADDR);
  end

  assign oDmaReg  = dma_reg_reg;
  assign oOamWe   = oam_we_reg;
  assign oOamAddr = oam_addr_reg;
  assign oOamData = oam_data_reg;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Self-checking bench for oam_dma_controller with default parameters.
// The source model returns addr[15:8]^addr[7:0], delayed CYCLES_PER_BYTE-1
// clocks, so each OAM byte n of a transfer from page P is expected as P^n
// (P after echo mapping).
module tb_oam_dma_controller;

  localparam int LEN   = 160;
  localparam int CPB   = 4;
  localparam int DLY   = 4;
  localparam int TOTAL = DLY + LEN * CPB + 1;

  logic        iClock = 1'b0;
  logic        iReset;
  logic [15:0] iCpuAddr;
  logic        iCpuWe;
  logic [7:0]  iCpuData;
  logic [7:0]  oDmaReg;
  logic        oDmaActive;
  logic        oCpuBlocked;
  logic [15:0] oDmaReadAddr;
  logic [7:0]  iDmaReadData;
  logic        oOamWe;
  logic [7:0]  oOamAddr;
  logic [7:0]  oOamData;

  oam_dma_controller #(.LENGTH(LEN), .CYCLES_PER_BYTE(CPB), .STARTUP_DELAY(DLY)) dut (
    .iClock(iClock), .iReset(iReset),
    .iCpuAddr(iCpuAddr), .iCpuWe(iCpuWe), .iCpuData(iCpuData),
    .oDmaReg(oDmaReg), .oDmaActive(oDmaActive), .oCpuBlocked(oCpuBlocked),
    .oDmaReadAddr(oDmaReadAddr), .iDmaReadData(iDmaReadData),
    .oOamWe(oOamWe), .oOamAddr(oOamAddr), .oOamData(oOamData)
  );

  always #5 iClock = ~iClock;

  // Source memory model with CPB-1 clocks of read latency
  logic [7:0] rd_pipe [CPB-1];
  always @(posedge iClock) begin
    rd_pipe[0] <= oDmaReadAddr[15:8] ^ oDmaReadAddr[7:0];
    for (int i = 1; i < CPB - 1; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign iDmaReadData = rd_pipe[CPB-2];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } exp_wr_t;

  typedef struct {
    logic [15:0] addr;
    logic        blocked_active;
  } blk_vec_t;

  exp_wr_t sb [$];
  int errors   = 0;
  int checks   = 0;
  int act_cnt  = 0;
  int we_total = 0;
  int wr_snap  = 0;
  logic [15:0] last_ra = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every OAM write is matched against the expected queue
  always @(negedge iClock) begin
    if (oDmaActive) begin
      act_cnt++;
      last_ra = oDmaReadAddr;
    end
    if (oOamWe) begin
      we_total++;
      if (sb.size() == 0) begin
        chk("unexpected_write", {8'h00, oOamAddr, 8'h00, oOamData}, 32'hFFFF_FFFF);
      end else begin
        exp_wr_t e;
        e = sb.pop_front();
        $display("oam write addr=%02h data=%02h exp=%02h/%02h", oOamAddr, oOamData, e.addr, e.data);
        chk("oam_addr", {24'h0, oOamAddr}, {24'h0, e.addr});
        chk("oam_data", {24'h0, oOamData}, {24'h0, e.data});
      end
    end
  end

  // Called just after a rising edge; trigger is sampled on the next edge
  task automatic trigger(input logic [7:0] v);
    logic [7:0] eff;
    iCpuAddr = 16'hFF46; iCpuWe = 1'b1; iCpuData = v;
    @(posedge iClock); #1;
    iCpuWe = 1'b0; iCpuAddr = 16'h0000; iCpuData = 8'h00;
    sb.delete();
    eff = (v >= 8'hE0) ? v - 8'h20 : v;
    for (int n = 0; n < LEN; n++) sb.push_back('{addr: 8'(n), data: eff ^ 8'(n)});
    act_cnt = 0;
    wr_snap = we_total;
    $display("trigger src=%02h", v);
  endtask

  task automatic wait_writes(input int n);
    int seen = 0;
    int budget = 0;
    while (seen < n && budget < 5000) begin
      @(posedge iClock); #1;
      if (oOamWe) seen++;
      budget++;
    end
    if (seen < n) chk("wait_writes_timeout", seen, n);
  endtask

  task automatic wait_done(input string tag);
    int budget = 0;
    while (oDmaActive && budget < 2000) begin
      @(posedge iClock); #1;
      budget++;
    end
    chk({tag, "_finished"}, {31'h0, oDmaActive}, 32'h0);
    chk({tag, "_active_clocks"}, act_cnt, TOTAL);
    chk({tag, "_write_count"}, we_total - wr_snap, LEN);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  blk_vec_t blk [7];

  initial begin
    blk[0] = '{16'hC000, 1'b1};
    blk[1] = '{16'hFF80, 1'b0};
    blk[2] = '{16'hFFFE, 1'b0};
    blk[3] = '{16'hFFFF, 1'b1};
    blk[4] = '{16'hFF46, 1'b0};
    blk[5] = '{16'hFF7F, 1'b1};
    blk[6] = '{16'h8000, 1'b1};

    // Reset state
    iReset = 1'b0; iCpuAddr = 16'hC000; iCpuWe = 1'b0; iCpuData = 8'h00;
    #2;
    chk("rst_active", {31'h0, oDmaActive}, 32'h0);
    chk("rst_blocked", {31'h0, oCpuBlocked}, 32'h0);
    chk("rst_we", {31'h0, oOamWe}, 32'h0);
    chk("rst_reg", {24'h0, oDmaReg}, 32'h0);
    chk("rst_readaddr", {16'h0, oDmaReadAddr}, 32'h0);
    chk("rst_oam", {16'h0, oOamAddr, oOamData}, 32'h0);
    repeat (3) @(posedge iClock);
    #1 iReset = 1'b1;
    repeat (2) @(posedge iClock);
    #1;

    // Idle: nothing is blocked
    for (int i = 0; i < 7; i++) begin
      iCpuAddr = blk[i].addr; #1;
      $display("idle blocked addr=%04h blocked=%0b", blk[i].addr, oCpuBlocked);
      chk($sformatf("idle_blocked_%04h", blk[i].addr), {31'h0, oCpuBlocked}, 32'h0);
    end
    iCpuAddr = 16'h0000;

    // Basic transfer from C100, with first-read and first-write timing
    trigger(8'hC1);
    chk("basic_active", {31'h0, oDmaActive}, 32'h1);
    chk("basic_reg", {24'h0, oDmaReg}, 32'hC1);
    repeat (DLY) @(posedge iClock);
    #1 chk("basic_first_readaddr", {16'h0, oDmaReadAddr}, 32'hC100);
    repeat (CPB - 1) @(posedge iClock);
    #1 chk("basic_no_early_we", {31'h0, oOamWe}, 32'h0);
    @(posedge iClock);
    #1 chk("basic_first_we", {31'h0, oOamWe}, 32'h1);
    repeat (20) @(posedge iClock);
    #1;
    for (int i = 0; i < 7; i++) begin
      iCpuAddr = blk[i].addr; #1;
      $display("active blocked addr=%04h blocked=%0b", blk[i].addr, oCpuBlocked);
      chk($sformatf("active_blocked_%04h", blk[i].addr), {31'h0, oCpuBlocked}, {31'h0, blk[i].blocked_active});
    end
    iCpuAddr = 16'h0000;
    wait_done("basic");

    // Echo: E3 reads from C300..C39F
    trigger(8'hE3);
    chk("echo_reg", {24'h0, oDmaReg}, 32'hE3);
    repeat (DLY) @(posedge iClock);
    #1 chk("echo_first_readaddr", {16'h0, oDmaReadAddr}, 32'hC300);
    wait_done("echo");
    chk("echo_last_readaddr", {16'h0, last_ra}, 32'hC39F);
    chk("idle_readaddr", {16'h0, oDmaReadAddr}, 32'h0);

    // Restart at byte 50: trigger lands on the edge that would capture byte 50
    trigger(8'hC0);
    wait_writes(50);
    repeat (CPB - 1) @(posedge iClock);
    #1;
    trigger(8'hD0);
    chk("restart_no_we", {31'h0, oOamWe}, 32'h0);
    chk("restart_reg", {24'h0, oDmaReg}, 32'hD0);
    repeat (DLY) @(posedge iClock);
    #1 chk("restart_readaddr", {16'h0, oDmaReadAddr}, 32'hD000);
    wait_done("restart");

    // Trigger during LAST: final write completes, then a new transfer starts
    trigger(8'hC4);
    wait_writes(LEN);
    chk("last_we_high", {31'h0, oOamWe}, 32'h1);
    chk("last_write_count", we_total + 1 - wr_snap, LEN);
    trigger(8'hC5);
    chk("last_restart_active", {31'h0, oDmaActive}, 32'h1);
    chk("last_restart_no_we", {31'h0, oOamWe}, 32'h0);
    wait_done("last_restart");

    // Asynchronous reset mid-transfer
    trigger(8'hC2);
    wait_writes(80);
    iCpuAddr = 16'hC000;
    iReset = 1'b0;
    #1;
    chk("midrst_active", {31'h0, oDmaActive}, 32'h0);
    chk("midrst_we", {31'h0, oOamWe}, 32'h0);
    chk("midrst_blocked", {31'h0, oCpuBlocked}, 32'h0);
    chk("midrst_reg", {24'h0, oDmaReg}, 32'h0);
    chk("midrst_readaddr", {16'h0, oDmaReadAddr}, 32'h0);
    chk("midrst_oam", {16'h0, oOamAddr, oOamData}, 32'h0);
    sb.delete();
    wr_snap = we_total;
    repeat (3) @(posedge iClock);
    #1 iReset = 1'b1;
    iCpuAddr = 16'h0000;
    repeat (200) @(posedge iClock);
    #1;
    chk("postrst_no_writes", we_total - wr_snap, 0);
    chk("postrst_idle", {31'h0, oDmaActive}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
